mem_arbiter: RTL
================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The parameter NUM_REQ SHALL default to 4 and set the number of requesters (2..8).
REQ-002 The parameter DATA SHALL default to 8 and set the data width in bits.
REQ-003 The parameter ADDR SHALL default to 16 and set the address width in bits.
REQ-004 The clk port SHALL be a 1-bit input and the single clock; all state updates on its posedge.
REQ-005 The rst port SHALL be a 1-bit input: synchronous, active-high reset.
REQ-006 The req port SHALL be a NUM_REQ-bit input carrying per-requester access requests.
REQ-007 The we port SHALL be a NUM_REQ-bit input: per-requester write (1) or read (0).
REQ-008 The addr port SHALL be a NUM_REQ x ADDR input carrying per-requester addresses.
REQ-009 The wdata port SHALL be a NUM_REQ x DATA input carrying per-requester write data.
REQ-010 The lock port SHALL be a NUM_REQ-bit input requesting a held grant (used only under REQ-030).
REQ-011 The gnt port SHALL be a NUM_REQ-bit output: one-hot, one-cycle request-accepted pulse.
REQ-012 The rvalid port SHALL be a NUM_REQ-bit output: one-hot, one-cycle read-data-valid pulse.
REQ-013 The rdata port SHALL be a DATA-bit output, shared read data, valid only while any rvalid bit is high.
REQ-014 The mem_addr, mem_wdata, mem_we and mem_re ports SHALL be outputs (ADDR, DATA, 1, 1 bits) driving the memory's single clocked read/write port.
REQ-015 The mem_rdata port SHALL be a DATA-bit input: registered memory read data, valid the cycle after mem_re.

Function
REQ-016 The FSM SHALL have states IDLE, ISSUE and RDWAIT.
REQ-017 In IDLE with any req bit high, the winner SHALL be the first requester with req high, searching round-robin from (last_winner+1) mod NUM_REQ; winner index, we, addr and wdata SHALL be registered and the state SHALL go to ISSUE.
REQ-018 In IDLE with no req high, the block SHALL stay in IDLE with all outputs inactive.
REQ-019 In ISSUE, gnt[winner] SHALL be 1 and mem_addr/mem_wdata SHALL present the captured values; mem_we = captured we, mem_re = not captured we.
REQ-020 From ISSUE, a write SHALL return to IDLE and a read SHALL go to RDWAIT.
REQ-021 In RDWAIT, rvalid[winner] SHALL be 1 and rdata SHALL equal mem_rdata, then the state SHALL return to IDLE.
REQ-022 Latency: a write SHALL take req-sampled edge to gnt in 1 cycle; a read SHALL take gnt to rvalid in 1 cycle; max throughput SHALL be one write per 2 cycles and one read per 3 cycles.
REQ-023 Requesters SHALL hold req, we, addr and wdata stable until gnt; they may drop or change them in the gnt cycle; req dropped before capture SHALL simply be ignored.
REQ-024 last_winner SHALL update only on capture; a requester with req held continuously SHALL be granted within NUM_REQ captures.
REQ-025 Outside ISSUE, mem_we and mem_re SHALL be 0; mem_addr and mem_wdata SHALL hold their last values.
REQ-026 Boundary: when only one requester asserts req, it SHALL win every capture regardless of last_winner; round-robin wrap from NUM_REQ-1 SHALL go to 0.

Reset
REQ-027 rst SHALL force IDLE, gnt=0, rvalid=0, mem_we=0, mem_re=0, mem_addr=0, mem_wdata=0, rdata=0 and last_winner=NUM_REQ-1 (so requester 0 wins first).
REQ-028 rst asserted in ISSUE or RDWAIT SHALL abort the access; no gnt or rvalid SHALL be issued for it after reset.
REQ-029 rst SHALL have priority over all other inputs in the same cycle.

Configuration
REQ-030 With macro MEM_ARBITER_LOCK_EN defined, a winner whose lock bit was high at capture SHALL win the next IDLE arbitration if its req is high, ignoring rotation, and last_winner SHALL not advance while the lock holds; without the macro, lock SHALL be ignored and arbitration SHALL be purely round-robin.

Structure
REQ-031 A package mem_arb_pkg SHALL hold the FSM state enum (IDLE, ISSUE, RDWAIT) and the default width constants.
REQ-032 The round-robin search SHALL be a combinational sub-module rr_picker (inputs req and last_winner; outputs winner index and valid).

Verification
REQ-033 Scenario single write: after reset, req=0001, we[0]=1, addr[0]=16'h1234, wdata[0]=8'hA5 -> next cycle gnt=0001, mem_we=1, mem_addr=16'h1234, mem_wdata=8'hA5; then IDLE.
REQ-034 Scenario read-after-write: req[2] reads 16'h1234 after REQ-033 -> gnt=0100, then rvalid=0100 and rdata=8'hA5.
REQ-035 Scenario fairness: req=1111 held for 8 captures -> grant order 0,1,2,3,0,1,2,3.
REQ-036 Scenario reset mid-read: rst pulsed in ISSUE of a read -> no rvalid; state IDLE; next capture with req=1111 grants requester 0.
REQ-037 Scenario lock (macro defined): req=0011, lock[1]=1 after requester 1 wins -> requester 1 granted repeatedly; after lock[1]=0, requester 0 granted next.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the memory arbiter.
// Optional held-grant arbitration is enabled with MEM_ARBITER_LOCK_EN.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    RDWAIT = 2'd2
  } state_t;

  localparam int DEF_NUM_REQ = 4;
  localparam int DEF_DATA    = 8;
  localparam int DEF_ADDR    = 16;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin search: first requester with req high,
// starting at (last_winner + 1) mod NUM_REQ.
module rr_picker #(
  parameter int NUM_REQ = 4,
  parameter int IDXW    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDXW-1:0]    last_winner,
  output logic [IDXW-1:0]    winner,
  output logic               valid
);

  logic [IDXW-1:0] cand;

  // Walk offsets from farthest to nearest so the nearest hit is kept.
  always_comb begin
    winner = '0;
    valid  = 1'b0;
    cand   = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      cand = IDXW'((int'(last_winner) + k) % NUM_REQ);
      if (req[cand]) begin
        winner = cand;
        valid  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one clocked memory port among NUM_REQ requesters.
// Define MEM_ARBITER_LOCK_EN to let a locked winner keep the grant.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int DATA    = DEF_DATA,
  parameter int ADDR    = DEF_ADDR
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ-1:0]            we,
  input  logic [NUM_REQ-1:0][ADDR-1:0]  addr,
  input  logic [NUM_REQ-1:0][DATA-1:0]  wdata,
  input  logic [NUM_REQ-1:0]            lock,
  output logic [NUM_REQ-1:0]            gnt,
  output logic [NUM_REQ-1:0]            rvalid,
  output logic [DATA-1:0]               rdata,
  output logic [ADDR-1:0]               mem_addr,
  output logic [DATA-1:0]               mem_wdata,
  output logic                          mem_we,
  output logic                          mem_re,
  input  logic [DATA-1:0]               mem_rdata
);

  localparam int IDXW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [NUM_REQ-1:0] ONE = NUM_REQ'(1);

  state_t          state;
  logic [IDXW-1:0] last_winner;
  logic [IDXW-1:0] winner;
  logic            we_cap;
  logic [IDXW-1:0] rr_winner;
  logic            rr_valid;
  logic [IDXW-1:0] pick;

  rr_picker #(
    .NUM_REQ (NUM_REQ),
    .IDXW    (IDXW)
  ) u_picker (
    .req         (req),
    .last_winner (last_winner),
    .winner      (rr_winner),
    .valid       (rr_valid)
  );

`ifdef MEM_ARBITER_LOCK_EN
  logic locked;
  logic lock_hit;
  // A locked previous winner that is still requesting bypasses rotation.
  assign lock_hit = locked && req[winner];
  assign pick     = lock_hit ? winner : rr_winner;
`else
  logic unused_lock;
  assign unused_lock = ^lock;
  assign pick        = rr_winner;
`endif

  // Memory read data is registered by the memory itself; pass it through
  // only while a read-valid pulse is out so idle rdata stays at zero.
  assign rdata = (|rvalid) ? mem_rdata : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      gnt         <= '0;
      rvalid      <= '0;
      mem_we      <= 1'b0;
      mem_re      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      winner      <= '0;
      we_cap      <= 1'b0;
      last_winner <= IDXW'(NUM_REQ - 1);
`ifdef MEM_ARBITER_LOCK_EN
      locked      <= 1'b0;
`endif
    end else begin
      gnt    <= '0;
      rvalid <= '0;
      mem_we <= 1'b0;
      mem_re <= 1'b0;
      case (state)
        IDLE: begin
          if (rr_valid) begin
            winner    <= pick;
            we_cap    <= we[pick];
            mem_addr  <= addr[pick];
            mem_wdata <= wdata[pick];
            mem_we    <= we[pick];
            mem_re    <= ~we[pick];
            gnt       <= ONE << pick;
            state     <= ISSUE;
`ifdef MEM_ARBITER_LOCK_EN
            if (!lock_hit) last_winner <= pick;
            locked <= lock[pick];
`else
            last_winner <= pick;
`endif
          end
        end
        ISSUE: begin
          if (we_cap) begin
            state <= IDLE;
          end else begin
            rvalid <= ONE << winner;
            state  <= RDWAIT;
          end
        end
        RDWAIT:  state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
